// File: rtl/sar_adc.sv
// Behavioural successive-approximation ADC: samples a real input on start and
// resolves it MSB-first, one bit per clock, against an ideal internal DAC threshold.
`timescale 1ns/1ps
module sar_adc #(
   parameter real Vref   = 3.3,
   parameter int  N_BITS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  real               A_in,
   output logic [N_BITS-1:0] D_out,
   output logic              valid,
   output logic              busy
);

   localparam int  KW         = $clog2(N_BITS);
   localparam real FULL_SCALE = 2.0 ** N_BITS;

   typedef enum logic {IDLE, CONVERT} state_t;

   state_t            state_q, state_d;
   real               sample_q, sample_d;
   logic [N_BITS-1:0] result_q, result_d;
   logic [KW-1:0]     k_q, k_d;
   logic [N_BITS-1:0] dout_q, dout_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic [N_BITS-1:0] trial;

   // Holding an over-range input at exactly Vref makes every trial succeed,
   // because the largest threshold is Vref*(2^N-1)/2^N < Vref.
   function automatic real clamp_input(input real a);
      if (a < 0.0)
         return 0.0;
      else if (a >= Vref)
         return Vref;
      else
         return a;
   endfunction

   function automatic real threshold(input logic [N_BITS-1:0] code);
      return Vref * real'(code) / FULL_SCALE;
   endfunction

   assign trial = result_q | (N_BITS'(1) << k_q);

   always_comb begin
      state_d  = state_q;
      sample_d = sample_q;
      result_d = result_q;
      k_d      = k_q;
      dout_d   = dout_q;
      valid_d  = 1'b0;
      busy_d   = busy_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sample_d = clamp_input(A_in);
               result_d = '0;
               k_d      = KW'(N_BITS - 1);
               busy_d   = 1'b1;
               state_d  = CONVERT;
            end
         end
         CONVERT: begin
            result_d = (sample_q >= threshold(trial)) ? trial : result_q;
            if (k_q == '0) begin
               dout_d  = result_d;
               valid_d = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               k_d = k_q - KW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sample_q <= 0.0;
         result_q <= '0;
         k_q      <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sample_q <= sample_d;
         result_q <= result_d;
         k_q      <= k_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   assign D_out = dout_q;
   assign valid = valid_q;
   assign busy  = busy_q;

endmodule
